kmp_pe: RTL and testbench



---
 rtl/kmp_pe_pkg.sv | 40 ++++
 rtl/kmp_fail_builder.sv | 67 ++++++
 rtl/kmp_pe.sv | 150 +++++++++++++++
 tb/tb_kmp_pe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/kmp_pe_pkg.sv
// Shared constants, types and helpers for the KMP processing element.
// Imported by kmp_fail_builder and kmp_pe.
package kmp_pe_pkg;

  localparam int CHAR_W      = 8;
  localparam int MAX_STR_LEN = 32;
  localparam int MAX_STR_ADD = 5;
  localparam int MAX_PAT_LEN = 8;
  localparam int MAX_PAT_ADD = 3;

  typedef enum logic [1:0] {
    PE_IDLE   = 2'd0,
    PE_BUILD  = 2'd1,
    PE_SEARCH = 2'd2,
    PE_DONE   = 2'd3
  } pe_state_e;

  typedef logic [CHAR_W-1:0]             char_t;
  typedef logic [MAX_STR_ADD-1:0]        str_idx_t;
  typedef logic [MAX_PAT_ADD-1:0]        pat_idx_t;
  typedef logic [MAX_STR_LEN*CHAR_W-1:0] str_flat_t;
  typedef logic [MAX_PAT_LEN*CHAR_W-1:0] pat_flat_t;

  function automatic char_t str_char(input str_flat_t s, input str_idx_t idx);
    return s[idx*CHAR_W +: CHAR_W];
  endfunction

  function automatic char_t pat_char(input pat_flat_t p, input pat_idx_t idx);
    return p[idx*CHAR_W +: CHAR_W];
  endfunction

  // Keeps the last searched index inside the string buffer.
  function automatic str_idx_t clamp_end(input str_idx_t idx);
    int e;
    e = int'(idx);
    if (e > MAX_STR_LEN - 1) e = MAX_STR_LEN - 1;
    return str_idx_t'(e);
  endfunction

endpackage

// File: rtl/kmp_fail_builder.sv
// Builds the KMP failure (prefix) table for a latched pattern, one compare per cycle.
// start initialises and clears the table; done is high in the cycle the table is complete.
module kmp_fail_builder
  import kmp_pe_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               abort,
  input  pat_flat_t                          pat,
  input  pat_idx_t                           pat_last_idx,
  output logic                               done,
  output logic [MAX_PAT_LEN*MAX_PAT_ADD-1:0] fail_flat
);

  logic                 busy;
  logic [MAX_PAT_ADD:0] k;
  pat_idx_t             len;
  pat_idx_t             fail_q [MAX_PAT_LEN];
  pat_idx_t             k_idx;

  assign k_idx = k[MAX_PAT_ADD-1:0];
  assign done  = busy && (k > {1'b0, pat_last_idx});

  // NOTE: the table is a handful of flops, not a RAM, so it is reset and
  // cleared on every start; a stale table can never leak into a new job.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      k    <= '0;
      len  <= '0;
      for (int e = 0; e < MAX_PAT_LEN; e++) fail_q[e] <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      k    <= (MAX_PAT_ADD+1)'(1);
      len  <= '0;
      for (int e = 0; e < MAX_PAT_LEN; e++) fail_q[e] <= '0;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else if (pat_char(pat, k_idx) == pat_char(pat, len)) begin
        fail_q[k_idx] <= len + 1'b1;
        len           <= len + 1'b1;
        k             <= k + 1'b1;
      end else if (len != '0) begin
        len <= fail_q[len - 1'b1];
      end else begin
        fail_q[k_idx] <= '0;
        k             <= k + 1'b1;
      end
    end
  end

  // NOTE: combinational outputs get a default before any loop or branch so
  // that no path leaves them unassigned and a latch is never inferred.
  always_comb begin
    fail_flat = '0;
    for (int e = 0; e < MAX_PAT_LEN; e++) begin
      fail_flat[e*MAX_PAT_ADD +: MAX_PAT_ADD] = fail_q[e];
    end
  end

endmodule

// File: rtl/kmp_pe.sv
// One KMP processing element: latches a job, builds the failure table, then scans
// the window [start_idx, process_2idx] and reports the first full pattern match.
module kmp_pe
  import kmp_pe_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pe_valid,
  input  logic [MAX_STR_ADD-1:0]        start_idx,
  input  logic [MAX_STR_ADD-1:0]        process_2idx,
  input  logic [MAX_STR_LEN*CHAR_W-1:0] str_data,
  input  logic [MAX_PAT_LEN*CHAR_W-1:0] pat_data,
  input  logic [MAX_PAT_ADD-1:0]        pat_last_idx,
  output logic                          o_match_valid,
  output logic                          o_match,
  output logic [MAX_STR_ADD-1:0]        o_match_idx
);

  pe_state_e state, state_n;

  str_idx_t  start_q, end_q;
  pat_idx_t  last_q;
  pat_flat_t pat_q;
  str_flat_t str_q;

  str_idx_t  i_q, i_n;
  pat_idx_t  j_q, j_n;
  logic      mv_n, m_n;
  str_idx_t  mi_n;

  logic      job_start;
  logic      build_done;
  logic      degenerate;
  logic      chars_eq;
  logic [MAX_PAT_LEN*MAX_PAT_ADD-1:0] fail_flat;

  kmp_fail_builder u_builder (
    .clk          (clk),
    .reset        (reset),
    .start        (job_start),
    .abort        (!pe_valid),
    .pat          (pat_q),
    .pat_last_idx (last_q),
    .done         (build_done),
    .fail_flat    (fail_flat)
  );

  // Job inputs are captured once; later changes on the ports are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= '0;
      end_q   <= '0;
      last_q  <= '0;
      pat_q   <= '0;
      str_q   <= '0;
    end else if (job_start) begin
      start_q <= start_idx;
      end_q   <= clamp_end(process_2idx);
      last_q  <= pat_last_idx;
      pat_q   <= pat_data;
      str_q   <= str_data;
    end
  end

  // Empty window, or one too short to hold the whole pattern.
  assign degenerate = (start_q > end_q) || ((end_q - start_q) < str_idx_t'(last_q));
  assign chars_eq   = (str_char(str_q, i_q) == pat_char(pat_q, j_q));

  always_comb begin
    state_n   = state;
    i_n       = i_q;
    j_n       = j_q;
    mv_n      = o_match_valid;
    m_n       = o_match;
    mi_n      = o_match_idx;
    job_start = 1'b0;

    if (!pe_valid) begin
      state_n = PE_IDLE;
      mv_n    = 1'b0;
      m_n     = 1'b0;
      mi_n    = '0;
    end else begin
      unique case (state)
        PE_IDLE: begin
          state_n   = PE_BUILD;
          job_start = 1'b1;
          i_n       = start_idx;
          j_n       = '0;
        end
        PE_BUILD: begin
          if (degenerate) begin
            state_n = PE_DONE;
            mv_n    = 1'b1;
            m_n     = 1'b0;
            mi_n    = '0;
          end else if (build_done) begin
            state_n = PE_SEARCH;
          end
        end
        PE_SEARCH: begin
          if (chars_eq && (j_q == last_q)) begin
            // j==last implies i>=start+last, so this cannot underflow.
            state_n = PE_DONE;
            mv_n    = 1'b1;
            m_n     = 1'b1;
            mi_n    = i_q - str_idx_t'(last_q);
          end else if (chars_eq || (j_q == '0)) begin
            if (i_q == end_q) begin
              state_n = PE_DONE;
              mv_n    = 1'b1;
              m_n     = 1'b0;
              mi_n    = '0;
            end else begin
              i_n = i_q + 1'b1;
              if (chars_eq) j_n = j_q + 1'b1;
            end
          end else begin
            j_n = fail_flat[(j_q - 1'b1)*MAX_PAT_ADD +: MAX_PAT_ADD];
          end
        end
        PE_DONE: begin
          state_n = PE_DONE;
        end
        default: begin
          state_n = PE_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= PE_IDLE;
      i_q           <= '0;
      j_q           <= '0;
      o_match_valid <= 1'b0;
      o_match       <= 1'b0;
      o_match_idx   <= '0;
    end else begin
      state         <= state_n;
      i_q           <= i_n;
      j_q           <= j_n;
      o_match_valid <= mv_n;
      o_match       <= m_n;
      o_match_idx   <= mi_n;
    end
  end

endmodule

// File: tb/tb_kmp_pe.sv
// Directed self-checking bench for kmp_pe: match, fallback, no-match, window edges,
// abort, asynchronous reset and hold-in-DONE behaviour.
module tb_kmp_pe;
  import kmp_pe_pkg::*;

  logic                          clk = 1'b0;
  logic                          reset = 1'b0;
  logic                          pe_valid = 1'b0;
  logic [MAX_STR_ADD-1:0]        start_idx = '0;
  logic [MAX_STR_ADD-1:0]        process_2idx = '0;
  logic [MAX_STR_LEN*CHAR_W-1:0] str_data = '0;
  logic [MAX_PAT_LEN*CHAR_W-1:0] pat_data = '0;
  logic [MAX_PAT_ADD-1:0]        pat_last_idx = '0;
  logic                          o_match_valid;
  logic                          o_match;
  logic [MAX_STR_ADD-1:0]        o_match_idx;

  int n_cmp = 0;
  int n_err = 0;
  int cycles;
  int held;

  kmp_pe dut (
    .clk           (clk),
    .reset         (reset),
    .pe_valid      (pe_valid),
    .start_idx     (start_idx),
    .process_2idx  (process_2idx),
    .str_data      (str_data),
    .pat_data      (pat_data),
    .pat_last_idx  (pat_last_idx),
    .o_match_valid (o_match_valid),
    .o_match       (o_match),
    .o_match_idx   (o_match_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fills the string with '.' and places s starting at index at.
  task automatic set_str(input string s, input int at);
    str_data = {MAX_STR_LEN{8'h2e}};
    for (int k = 0; k < s.len(); k++) str_data[(at+k)*CHAR_W +: CHAR_W] = s[k];
  endtask

  task automatic set_pat(input string s);
    pat_data = '0;
    for (int k = 0; k < s.len(); k++) pat_data[k*CHAR_W +: CHAR_W] = s[k];
    pat_last_idx = MAX_PAT_ADD'(s.len() - 1);
  endtask

  task automatic start_job(input int s, input int e);
    @(negedge clk);
    start_idx    = MAX_STR_ADD'(s);
    process_2idx = MAX_STR_ADD'(e);
    pe_valid     = 1'b1;
  endtask

  task automatic wait_result(input string tag, input int budget, output int n);
    n = 0;
    while (!o_match_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(o_match_valid), 32'd1);
  endtask

  task automatic expect_result(input string tag, input logic m, input int idx);
    check({tag, "_match"}, 32'(o_match), 32'(m));
    check({tag, "_idx"}, 32'(o_match_idx), 32'(idx));
  endtask

  task automatic drop_and_check(input string tag);
    @(negedge clk);
    pe_valid = 1'b0;
    @(negedge clk);
    check({tag, "_drop_valid"}, 32'(o_match_valid), 32'd0);
    check({tag, "_drop_match"}, 32'(o_match), 32'd0);
    check({tag, "_drop_idx"}, 32'(o_match_idx), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", 32'(o_match_valid), 32'd0);
    check("rst_match", 32'(o_match), 32'd0);
    check("rst_idx", 32'(o_match_idx), 32'd0);
    check("rst_table", 32'(dut.u_builder.fail_flat), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic match; inputs scrambled after latch must be ignored
    set_str("xxABCxxx", 0);
    set_pat("ABC");
    start_job(0, 7);
    @(negedge clk);
    str_data  = {MAX_STR_LEN{8'h2e}};
    start_idx = 5'd5;
    pat_data  = '0;
    wait_result("basic", 40, cycles);
    expect_result("basic", 1'b1, 2);
    held = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_match_valid && o_match && o_match_idx == 5'd2) held++;
    end
    check("basic_hold_cycles", 32'(held), 32'd10);
    drop_and_check("basic");

    // Fallback path through j = fail[j-1]
    set_str("AAAAB", 0);
    set_pat("AAB");
    start_job(0, 4);
    wait_result("fallback", 40, cycles);
    expect_result("fallback", 1'b1, 2);
    check("fallback_table", 32'(dut.u_builder.fail_flat), 32'h000008);
    drop_and_check("fallback");

    // No match, bounded latency
    str_data = {MAX_STR_LEN{8'h41}};
    set_pat("ZZ");
    start_job(8, 15);
    wait_result("nomatch", 24, cycles);
    expect_result("nomatch", 1'b0, 0);
    check("nomatch_latency_ok", 32'(cycles <= 24), 32'd1);
    drop_and_check("nomatch");

    // Window end: pattern at 14..16
    set_str("ABC", 14);
    set_pat("ABC");
    start_job(8, 15);
    wait_result("straddle", 40, cycles);
    expect_result("straddle", 1'b0, 0);
    drop_and_check("straddle");

    start_job(8, 16);
    wait_result("edge_fit", 40, cycles);
    expect_result("edge_fit", 1'b1, 14);
    drop_and_check("edge_fit");

    start_job(20, 5);
    wait_result("inverted", 3, cycles);
    expect_result("inverted", 1'b0, 0);
    drop_and_check("inverted");

    // Abort mid-SEARCH, then a fresh job with a different table
    str_data = {MAX_STR_LEN{8'h41}};
    set_pat("AAAZ");
    start_job(0, 31);
    repeat (8) @(negedge clk);
    check("abort_busy_valid", 32'(o_match_valid), 32'd0);
    drop_and_check("abort");
    set_str("AAAAB", 0);
    set_pat("AAB");
    start_job(0, 4);
    wait_result("after_abort", 40, cycles);
    expect_result("after_abort", 1'b1, 2);
    check("after_abort_table", 32'(dut.u_builder.fail_flat), 32'h000008);
    drop_and_check("after_abort");

    // Asynchronous reset mid-BUILD
    set_str("ABCDEFGH", 0);
    set_pat("ABCDEFGH");
    start_job(0, 31);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_build_valid", 32'(o_match_valid), 32'd0);
    check("rst_build_table", 32'(dut.u_builder.fail_flat), 32'd0);
    pe_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset while holding a result in DONE
    set_str("xxABCxxx", 0);
    set_pat("ABC");
    start_job(0, 7);
    wait_result("pre_rst", 40, cycles);
    expect_result("pre_rst", 1'b1, 2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_done_valid", 32'(o_match_valid), 32'd0);
    check("rst_done_match", 32'(o_match), 32'd0);
    check("rst_done_idx", 32'(o_match_idx), 32'd0);
    pe_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_idle_valid", 32'(o_match_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
